sobel_grad_sq: RTL
==================

Name: sobel_grad_sq

Overview:
- Streaming Sobel front-end that directly feeds the approximate square-root stage.
- Accepts a raster-scan 8-bit grey pixel stream and buffers two image lines in internal line buffers.
- Forms a 3x3 window and computes Gx and Gy, then emits the 16-bit squared-magnitude word R consumed by the sqrt stage.
- Output is fixed-latency and has no backpressure, because the downstream sqrt is purely combinational.

Parameters:
- IMG_W, 64, pixels per line; legal range 3..1024.
- IMG_H, 64, lines per frame; legal range 3..1024.
- PIX_W, 8, pixel width; fixed at 8 for this release.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel qualifier; when high, in_pixel is accepted this cycle; gaps are allowed.
- in_sof  in  1  start of frame; valid only with in_valid; marks pixel (0,0).
- in_pixel  in  8  unsigned grey level.
- out_valid  out  1  out_r is valid this cycle.
- out_r  out  16  saturated squared gradient magnitude; goes straight to the sqrt R input.
- out_eof  out  1  high with the last interior result of a frame.

Behaviour:
- Reset: out_valid=0, out_r=0, out_eof=0. Row/column counters=0, pipeline valid bits=0.
  - Line-buffer contents are don't-care; outputs are gated by the counters.
- Counters: col increments on each accepted pixel and wraps IMG_W-1 -> 0, which increments row.
  - row wraps IMG_H-1 -> 0.
  - in_sof with in_valid forces this pixel to (0,0) regardless of current counts, so a partial frame is abandoned.
- Line buffers: two IMG_W-deep 8-bit buffers.
  - Each accepted pixel pushes column col through them, shifting the older line.
  - 3x3 window registers p[r][c]: r=0 is the oldest line, c=0 the oldest column.
- Window completion: a window is complete when the accepted pixel has row>=2 and col>=2. Its centre is (row-1, col-1).
  - Border pixels produce no output.
  - Per frame there are exactly (IMG_W-2)*(IMG_H-2) results.
- Gradients, 11-bit signed:
  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20)
  - Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02)
  - Both range -1020..1020.
- Scaling: ax = |Gx|>>2 and ay = |Gy|>>2 (0..255, 8-bit). s = ax*ax + ay*ay is 17-bit. out_r = (s > 65535) ? 65535 : s.
- Pipeline, 3 registered stages that advance every cycle independent of in_valid:
  - S1: window/valid capture.
  - S2: Gx, Gy.
  - S3: abs, shift, squares, sum, saturate.
  - out_valid asserts exactly 3 cycles after the in_valid cycle that completed the window, for one cycle per result.
- out_eof asserts with the result whose window completed at row=IMG_H-1, col=IMG_W-1.
- Between results, out_r holds its last value and out_valid=0.
- Asynchronous reset mid-frame: pipeline is flushed (no stale out_valid), and the next in_sof starts cleanly.
- Pixels arriving before the first in_sof after reset are counted from (0,0).

Optional Feature:
- Macro: SOBEL_SAT_FLAG_EN.
- Defined: adds output port out_sat (1 bit), reset to 0, aligned with out_valid. It is high when s > 65535 (the clamp was applied).
- Undefined: no out_sat port and no comparator beyond the clamp itself.
- out_r behaviour is identical in both builds.

Decomposition:
- Shared package sobel_pkg holds:
  - pixel width constant PIX_W=8, gradient width GRAD_W=11, result width R_W=16;
  - R_MAX=16'hFFFF;
  - the pixel_t and grad_t typedefs.
- One natural sub-module: sobel_line_buf, a parameterised IMG_W-deep, 8-bit delay line instantiated twice. Counters, window and arithmetic stay in the top.

Test Plan:
- Constant image, all pixels 100, 8x8 -> 36 results, all out_r=0, out_eof on the 36th, no output for border pixels.
- Vertical step, 16x8, cols 0..7=0 and cols 8..15=255 -> per row, centres col 7 and 8 give Gx=1020, out_r=65025; all other centres 0; Gy=0 throughout.
- Anti-diagonal, pixel=255 iff row+col>=S -> centres with row+col=S-1 give Gx=Gy=765, ax=ay=191, s=72962, out_r=65535, out_sat=1 when SOBEL_SAT_FLAG_EN.
- Gapped input, in_valid toggling 1/0 on the step image -> identical result sequence to the gap-free run; each out_valid exactly 3 cycles after its completing pixel.
- Mid-frame rst_n pulse at row 3 -> out_valid=0 within the reset, no residual outputs; a fresh frame with in_sof reproduces the golden 36 results.
- in_sof reasserted at row 4 of an 8x8 frame -> counters restart; the first result only after row 2/col 2 of the new frame; no result mixes old-frame rows.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types, widths and arithmetic helpers for the Sobel squared-gradient block.
// Contents: pixel/gradient typedefs, result width and clamp value, tap-sum,
// gradient-difference and magnitude-quantise helpers.
package sobel_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned GRAD_W = 11;
  localparam int unsigned R_W    = 16;
  localparam int unsigned SUM_W  = 10;   // a + 2b + c of three pixels, max 1020
  localparam int unsigned SQ_W   = 17;   // ax*ax + ay*ay, max 130050

  localparam logic [R_W-1:0] R_MAX = 16'hFFFF;

  typedef logic [PIX_W-1:0]         pixel_t;
  typedef logic signed [GRAD_W-1:0] grad_t;

  // Weighted 1-2-1 sum of one window edge.
  function automatic logic [SUM_W-1:0] tap_sum(input pixel_t a, input pixel_t b,
                                               input pixel_t c);
    return SUM_W'(a) + SUM_W'({b, 1'b0}) + SUM_W'(c);
  endfunction

  // Positive edge sum minus negative edge sum.
  function automatic grad_t tap_diff(input pixel_t p0, input pixel_t p1, input pixel_t p2,
                                     input pixel_t n0, input pixel_t n1, input pixel_t n2);
    return $signed({1'b0, tap_sum(p0, p1, p2)}) - $signed({1'b0, tap_sum(n0, n1, n2)});
  endfunction

  // |g| >> 2, always fits 8 bits since |g| <= 1020.
  function automatic pixel_t abs_q(input grad_t g);
    logic [GRAD_W-1:0] mag;
    mag = g[GRAD_W-1] ? GRAD_W'(-g) : GRAD_W'(g);
    return PIX_W'(mag >> 2);
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One-line pixel delay line addressed by column.
// Reading addr returns the pixel written at that column one line earlier; the
// same cycle's write replaces it. Contents are not reset.
// Ports: clk, en (write strobe), addr (column), din (pixel in), dout_c (comb. read).
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  pixel_t        din,
  output pixel_t        dout_c
);

  pixel_t mem [DEPTH];

  assign dout_c = mem[addr];

  // Storage only; validity is tracked by the frame counters upstream.
  always_ff @(posedge clk) begin
    if (en) mem[addr] <= din;
  end

endmodule

// File: rtl/sobel_grad_sq.sv
// Streaming Sobel front-end producing the saturated squared gradient magnitude.
// Raster pixels are counted into (row, col), two line buffers supply the two
// previous lines, a 3x3 window feeds a 3-stage pipeline:
//   S1 window/valid capture, S2 Gx/Gy, S3 |.|>>2, squares, sum, clamp.
// Ports: clk, rst_n (async active-low), in_valid, in_sof, in_pixel[7:0],
//        out_valid, out_r[15:0], out_eof, and out_sat when SOBEL_SAT_FLAG_EN
//        is defined (high with a result whose sum was clamped).
module sobel_grad_sq
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  output logic [R_W-1:0]   out_r,
  output logic             out_eof
`ifdef SOBEL_SAT_FLAG_EN
  ,
  output logic             out_sat
`endif
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  // ---------------- position of the current pixel ----------------
  logic [COL_W-1:0] col, col_cur;
  logic [ROW_W-1:0] row, row_cur;
  logic             col_last, row_last, win_done;

  // in_sof overrides the running counts so a partial frame is dropped.
  always_comb begin
    col_cur  = in_sof ? '0 : col;
    row_cur  = in_sof ? '0 : row;
    col_last = (col_cur == COL_W'(IMG_W - 1));
    row_last = (row_cur == ROW_W'(IMG_H - 1));
    win_done = in_valid && (row_cur >= ROW_W'(2)) && (col_cur >= COL_W'(2));
  end

  // Raster counters advance on accepted pixels only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row_cur + ROW_W'(1);
      end else begin
        col <= col_cur + COL_W'(1);
        row <= row_cur;
      end
    end
  end

  // ---------------- line buffers: up1 = row-1, up2 = row-2 ----------------
  pixel_t up1, up2;

  sobel_line_buf #(.DEPTH(IMG_W)) u_lb_1 (
    .clk    (clk),
    .en     (in_valid),
    .addr   (col_cur),
    .din    (in_pixel),
    .dout_c (up1)
  );

  sobel_line_buf #(.DEPTH(IMG_W)) u_lb_2 (
    .clk    (clk),
    .en     (in_valid),
    .addr   (col_cur),
    .din    (up1),
    .dout_c (up2)
  );

  // ---------------- S1: window shift and completion flags ----------------
  pixel_t win [3][3];   // [line][column], index 0 is oldest
  logic   v1, e1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      e1 <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
      end
    end else begin
      v1 <= win_done;
      e1 <= win_done && row_last && col_last;
      if (in_valid) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= up2;
        win[1][2] <= up1;
        win[2][2] <= in_pixel;
      end
    end
  end

  // ---------------- S2: gradients ----------------
  grad_t gx, gy;
  logic  v2, e2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      e2 <= 1'b0;
      gx <= '0;
      gy <= '0;
    end else begin
      v2 <= v1;
      e2 <= e1;
      if (v1) begin
        gx <= tap_diff(win[0][2], win[1][2], win[2][2], win[0][0], win[1][0], win[2][0]);
        gy <= tap_diff(win[2][0], win[2][1], win[2][2], win[0][0], win[0][1], win[0][2]);
      end
    end
  end

  // ---------------- S3: magnitude squared and clamp ----------------
  logic [SQ_W-1:0] ax, ay, sq_sum;
  logic            sat;

  // Sum never reaches 2^17, so bit 16 alone flags the overflow.
  always_comb begin
    ax     = SQ_W'(abs_q(gx));
    ay     = SQ_W'(abs_q(gy));
    sq_sum = ax * ax + ay * ay;
    sat    = sq_sum[SQ_W-1];
  end

  // out_r holds its last value between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      out_r     <= '0;
    end else begin
      out_valid <= v2;
      out_eof   <= v2 && e2;
      if (v2) out_r <= sat ? R_MAX : sq_sum[R_W-1:0];
    end
  end

`ifdef SOBEL_SAT_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_sat <= 1'b0;
    else        out_sat <= v2 && sat;
  end
`endif

endmodule
